// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write path: FSM encoding, word layout, common characters.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// A display word is 9 bits: [8] = RS (0 command, 1 data), [7:0] = byte for the controller.
package lcd_pkg;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_BUSY = 3'd2,
    ST_GAP  = 3'd3,
    ST_ACK  = 3'd4
  } lcdState_t;

  // Word field layout.
  localparam int WORD_W  = 9;
  localparam int RS_BIT  = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  // Characters and commands shared by the stopwatch and lap-record writers.
  localparam logic [WORD_W-1:0] CH_SPACE  = 9'h120;
  localparam logic [WORD_W-1:0] CH_COLON  = 9'h13A;
  localparam logic [WORD_W-1:0] CMD_LINE2 = 9'h0C0;

  function automatic logic wordRs(input logic [WORD_W-1:0] w);
    return w[RS_BIT];
  endfunction

  function automatic logic [7:0] wordData(input logic [WORD_W-1:0] w);
    return w[DATA_HI:DATA_LO];
  endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Two-way round-robin pick: chooses which requester wins when both ask at once.
// Latency: grant is combinational; the pointer updates on the clock edge where iUpdate is high.
// Backpressure: none; the caller decides when to consume the grant and when to move the pointer.
//
// Ports:
//   iCLK, iRST_N  clock, async active-low reset (pointer returns to 0)
//   iReq0, iReq1  request lines
//   iUpdate       a burst is ending this cycle; move the pointer away from iLastOwner
//   iLastOwner    index of the requester whose burst is ending
//   oGrant        index of the winner (only meaningful while oAny is high)
//   oAny          at least one request is present
module lcd_rr_pick (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iReq0,
  input  logic iReq1,
  input  logic iUpdate,
  input  logic iLastOwner,
  output logic oGrant,
  output logic oAny
);

  // rr names the requester that wins the next simultaneous contest.
  logic rr;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rr <= 1'b0;
    end else if (iUpdate) begin
      rr <= ~iLastOwner;
    end
  end

  always_comb begin
    oAny = iReq0 | iReq1;
    if (iReq0 && iReq1) begin
      oGrant = rr;
    end else begin
      // A single requester wins outright; with no request the value is unused.
      oGrant = iReq1;
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares one LCD byte-write engine between two burst requesters with post-write settling and done-timeout.
// Latency: oLCD_Start rises 2 edges after a request is sampled; each ack follows iLCD_Done by DLY_CYCLES idle cycles.
// Backpressure: a requester holds iReq and its word until oAck; the non-owner waits for the whole burst.
//
// Ports:
//   iCLK, iRST_N              clock, async active-low reset
//   iReqN/iDataN/iLastN       requester N: word pending, {RS,data} word, word ends the burst
//   oAckN                     one-cycle pulse: requester N's word is written, present the next one
//   oLCD_DATA/oLCD_RS         byte and register select to the LCD controller
//   oLCD_Start/iLCD_Done      start/done handshake with the LCD controller
//   oBusy                     arbiter is not idle
//   oOwner                    current or most recent grantee
//   oTimeout                  sticky: the engine once failed to report done in time
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int DLY_W      = 18,
  parameter int DLY_CYCLES = 262143,
  parameter int TO_W       = 16,
  parameter int TO_CYCLES  = 65535
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iReq0,
  input  logic [8:0] iData0,
  input  logic       iLast0,
  output logic       oAck0,
  input  logic       iReq1,
  input  logic [8:0] iData1,
  input  logic       iLast1,
  output logic       oAck1,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_Start,
  input  logic       iLCD_Done,
  output logic       oBusy,
  output logic       oOwner,
  output logic       oTimeout
);

  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYCLES - 1);

  // Registered state.
  lcdState_t        state;
  logic             lastQ;
  logic [DLY_W-1:0] dlyCnt;
  logic [TO_W-1:0]  toCnt;

  // Next values computed by the combinational processes.
  lcdState_t        stateNext;
  logic             ownerNxt;
  logic [7:0]       dataNxt;
  logic             rsNxt;
  logic             lastNxt;
  logic             startNxt;
  logic             timeoutNxt;
  logic             ack0Nxt;
  logic             ack1Nxt;
  logic             busyNxt;
  logic [DLY_W-1:0] dlyNxt;
  logic [TO_W-1:0]  toNxt;
  logic             rrUpdate;

  // Decode helpers.
  logic              anyReq;
  logic              grantIdx;
  logic              ownerReq;
  logic              ownerLast;
  logic [WORD_W-1:0] ownerWord;
  logic              toExpire;
  logic              dlyDone;

  lcd_rr_pick uPick (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iReq0      (iReq0),
    .iReq1      (iReq1),
    .iUpdate    (rrUpdate),
    .iLastOwner (oOwner),
    .oGrant     (grantIdx),
    .oAny       (anyReq)
  );

  // Only the owner's lines are ever looked at once a burst is granted; this is the lock.
  assign ownerReq  = oOwner ? iReq1  : iReq0;
  assign ownerLast = oOwner ? iLast1 : iLast0;
  assign ownerWord = oOwner ? iData1 : iData0;
  assign toExpire  = (toCnt == TO_LAST);
  assign dlyDone   = (dlyCnt == DLY_LAST);

  // State and output registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= ST_IDLE;
      oOwner     <= 1'b0;
      oLCD_DATA  <= 8'h00;
      oLCD_RS    <= 1'b0;
      lastQ      <= 1'b0;
      oLCD_Start <= 1'b0;
      oTimeout   <= 1'b0;
      oAck0      <= 1'b0;
      oAck1      <= 1'b0;
      oBusy      <= 1'b0;
      dlyCnt     <= '0;
      toCnt      <= '0;
    end else begin
      state      <= stateNext;
      oOwner     <= ownerNxt;
      oLCD_DATA  <= dataNxt;
      oLCD_RS    <= rsNxt;
      lastQ      <= lastNxt;
      oLCD_Start <= startNxt;
      oTimeout   <= timeoutNxt;
      oAck0      <= ack0Nxt;
      oAck1      <= ack1Nxt;
      oBusy      <= busyNxt;
      dlyCnt     <= dlyNxt;
      toCnt      <= toNxt;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (anyReq) begin
          stateNext = ST_LOAD;
        end
      end
      ST_LOAD: begin
        stateNext = ST_BUSY;
      end
      ST_BUSY: begin
        // A timeout is treated exactly like a completed write so the burst keeps moving.
        if (iLCD_Done || toExpire) begin
          stateNext = ST_GAP;
        end
      end
      ST_GAP: begin
        if (dlyDone) begin
          stateNext = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!lastQ && ownerReq) begin
          stateNext = ST_LOAD;
        end else begin
          stateNext = ST_IDLE;
        end
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    ownerNxt   = oOwner;
    dataNxt    = oLCD_DATA;
    rsNxt      = oLCD_RS;
    lastNxt    = lastQ;
    startNxt   = oLCD_Start;
    timeoutNxt = oTimeout;
    dlyNxt     = dlyCnt;
    toNxt      = toCnt;
    ack0Nxt    = 1'b0;
    ack1Nxt    = 1'b0;
    rrUpdate   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (anyReq) begin
          ownerNxt = grantIdx;
        end
      end
      ST_LOAD: begin
        dataNxt  = wordData(ownerWord);
        rsNxt    = wordRs(ownerWord);
        lastNxt  = ownerLast;
        startNxt = 1'b1;
        toNxt    = '0;
      end
      ST_BUSY: begin
        if (iLCD_Done) begin
          startNxt = 1'b0;
        end else if (toExpire) begin
          timeoutNxt = 1'b1;
          startNxt   = 1'b0;
        end else begin
          toNxt = toCnt + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (dlyDone) begin
          dlyNxt = '0;
          // Ack is registered, so it is raised on the edge that enters ACK.
          ack0Nxt = ~oOwner;
          ack1Nxt = oOwner;
        end else begin
          dlyNxt = dlyCnt + DLY_W'(1);
        end
      end
      ST_ACK: begin
        // Burst over (last word, or the owner walked away): hand priority to the other side.
        if (lastQ || !ownerReq) begin
          rrUpdate = 1'b1;
        end
      end
      default: begin
        startNxt = 1'b0;
      end
    endcase

    busyNxt = (stateNext != ST_IDLE);
  end

endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Shares one LCD byte-write engine (LCD_Controller: data/RS/start/done handshake) between two requesters, e.g. the live stopwatch writer and the lap-record writer.
- Grants the engine per burst. A burst is a sequence of 9-bit {RS,data} words ending with a "last" flag, so display lines never interleave.
- Inserts the mandatory post-write settling delay after every word.
- Guards against a hung engine with a done-timeout.

Parameters:
- DLY_W, 18, width of the post-write delay counter.
- DLY_CYCLES, 262143, idle cycles after each iLCD_Done before the word is acknowledged (must be ≥1 and < 2^DLY_W).
- TO_W, 16, width of the timeout counter.
- TO_CYCLES, 65535, maximum cycles in BUSY awaiting iLCD_Done (must be ≥1 and < 2^TO_W).

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iReq0  in  1  requester 0 has a word pending; held high for the whole burst
- iData0  in  9  requester 0 word: [8]=RS, [7:0]=data
- iLast0  in  1  requester 0 current word ends its burst
- oAck0  out  1  one-cycle pulse: requester 0 word written; advance to the next word
- iReq1, iData1, iLast1, oAck1: same as requester 0, for requester 1
- oLCD_DATA  out  8  byte to LCD_Controller iDATA
- oLCD_RS  out  1  to LCD_Controller iRS
- oLCD_Start  out  1  to LCD_Controller iStart
- iLCD_Done  in  1  from LCD_Controller oDone
- oBusy  out  1  high in every state except IDLE
- oOwner  out  1  index of the current or most recent grantee
- oTimeout  out  1  sticky flag; set on a done-timeout, cleared only by reset

Behaviour:
- Reset (async, iRST_N low): state IDLE; all outputs 0; round-robin pointer rr=0; counters 0. Takes effect immediately mid-burst, and oLCD_Start drops without waiting for iLCD_Done.
- All outputs are registered. The FSM has states IDLE, LOAD, BUSY, GAP and ACK.
- IDLE:
  - If exactly one iReqN is high: owner<=N.
  - If both are high: owner<=rr.
  - In either case, next state is LOAD. With no request, stay in IDLE.
- LOAD:
  - Sample iData[owner] and iLast[owner] into oLCD_RS/oLCD_DATA and an internal last_q.
  - oLCD_Start<=1; timeout counter<=0; next state BUSY.
  - oLCD_Start is therefore first high 2 edges after the request is sampled in IDLE.
- BUSY:
  - If iLCD_Done is high: oLCD_Start<=0 and go to GAP.
  - Else if the timeout counter == TO_CYCLES-1: oTimeout<=1, oLCD_Start<=0 and go to GAP, treating the word as written.
  - Else increment the timeout counter.
  - oLCD_DATA and oLCD_RS stay stable throughout BUSY.
- GAP:
  - The delay counter counts 0..DLY_CYCLES-1, then resets to 0 and the FSM goes to ACK.
  - Exactly DLY_CYCLES cycles are spent in GAP.
- ACK:
  - oAck[owner]=1 for exactly this cycle.
  - If last_q: rr<=~owner and go to IDLE (lock released).
  - Else if iReq[owner] is still high: go to LOAD. The requester must present its next word by the cycle after the ack.
  - Else (requester abandoned the burst): rr<=~owner and go to IDLE.
- Lock: the non-owner's request is ignored for the whole burst, regardless of rr.
- Fairness: after any burst ends, the other requester wins a simultaneous contest. Alternation is strict under continuous contention.
- The requesters' iData, iLast and iReq inputs are only sampled in LOAD/ACK/IDLE, as above.
- oAck0 and oAck1 are never high together.
- oBusy = (state != IDLE). oOwner holds its value through IDLE.

Decomposition:
- Shared package lcd_pkg:
  - FSM state encoding.
  - Word field indices (RS bit 8, data bits 7:0).
  - Common character constants (9'h120 space, 9'h13A colon, 9'h0C0 line-2 address) used by both writers.
- One natural sub-module: lcd_rr_pick. A 2-way round-robin grant with pointer-update input, combinational plus the rr flop.
- The delay and timeout counters stay inline.

Test Plan (DLY_CYCLES=4, TO_CYCLES=10, engine model raises done 3 cycles after start):
1. Single burst: iReq0=1 with words 9'h038, 9'h13A(last).
   - oLCD_Start high 2 edges after req; data 38/RS0, then 3A/RS1.
   - Two oAck0 pulses, each 4 cycles after the corresponding done.
   - Ends in IDLE, rr=1.
2. Simultaneous requests from reset, both bursts 2 words:
   - Owner0 is served fully first, then owner1.
   - A second simultaneous contest is won by 0 again (rr toggled to 0 after 1's burst).
3. Lock: raise iReq1 during word 1 of a 3-word burst from requester 0.
   - No oAck1 and no requester-1 data on oLCD_DATA until after 0's third oAck0.
4. Abort: requester 0 drops iReq0 in the ACK cycle of a non-last word.
   - FSM goes to IDLE; a pending iReq1 is granted next.
5. Timeout: engine model never asserts done.
   - oLCD_Start falls after 10 BUSY cycles; oTimeout=1 and stays set.
   - oAck0 follows 4 cycles later.
   - A subsequent burst still completes normally.
6. Reset mid-BUSY: pulse iRST_N low asynchronously.
   - oLCD_Start, oAck*, oBusy and oTimeout are 0 immediately.
   - After release, state is IDLE and rr=0.
